// File: rtl/mips_multicycle.sv
// Multicycle MIPS Lite core: one-hot FSM over a shared ALU and one valid/ready memory port.
// Define MIPS_MC_BNE_EN to add bne (opcode 6'b000101); otherwise it decodes as illegal.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [31:0]           pc,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  illegal
);
`ifdef MIPS_MC_BNE_EN
    localparam bit BneEn = 1'b1;
`else
    localparam bit BneEn = 1'b0;
`endif

    localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2b;
    localparam logic [2:0] AluAnd = 3'b000, AluOr = 3'b001, AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110, AluSlt = 3'b111;

    typedef enum logic [11:0] {
        StFetch  = 12'h001, StDecode = 12'h002, StMemAdr = 12'h004, StMemRd  = 12'h008,
        StMemWb  = 12'h010, StMemWr  = 12'h020, StExec   = 12'h040, StAluWb  = 12'h080,
        StBranch = 12'h100, StAddiEx = 12'h200, StAddiWb = 12'h400, StJump   = 12'h800
    } state_e;

    state_e      r_state, w_state_next;
    logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_rf_waddr;
    logic [31:0] w_imm_se, w_rs_val, w_rt_val, w_alu_a, w_alu_b, w_alu_y, w_rf_wdata;
    logic [31:0] w_byte_addr, w_addr_full;
    logic [2:0]  w_alu_ctl, w_funct_ctl;
    logic        w_funct_ok, w_legal, w_take, w_addr_sel, w_ir_we, w_mdr_we, w_ab_we;
    logic        w_alu_we, w_pc_br, w_pc_jmp, w_rf_we, w_unused;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_imm_se = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
    assign w_take   = (r_a == r_b) ^ (BneEn && (w_op == OpBne));

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_ctl = AluAdd;
        case (w_funct)
            6'h20:   w_funct_ctl = AluAdd;
            6'h22:   w_funct_ctl = AluSub;
            6'h24:   w_funct_ctl = AluAnd;
            6'h25:   w_funct_ctl = AluOr;
            6'h2a:   w_funct_ctl = AluSlt;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (w_op)
            OpRtype:                         w_legal = w_funct_ok;
            OpLw, OpSw, OpBeq, OpAddi, OpJ: w_legal = 1'b1;
            OpBne:                           w_legal = BneEn;
            default:                         w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (w_alu_ctl)
            AluAnd:  w_alu_y = w_alu_a & w_alu_b;
            AluOr:   w_alu_y = w_alu_a | w_alu_b;
            AluSub:  w_alu_y = w_alu_a - w_alu_b;
            AluSlt:  w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            default: w_alu_y = w_alu_a + w_alu_b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StFetch;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch:  if (mem_ready) w_state_next = StDecode;
            StDecode: begin
                w_state_next = StFetch;
                if (w_legal) begin
                    case (w_op)
                        OpRtype:     w_state_next = StExec;
                        OpLw, OpSw:  w_state_next = StMemAdr;
                        OpBeq, OpBne: w_state_next = StBranch;
                        OpAddi:      w_state_next = StAddiEx;
                        OpJ:         w_state_next = StJump;
                        default:     w_state_next = StFetch;
                    endcase
                end
            end
            StMemAdr: w_state_next = (w_op == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) w_state_next = StMemWb;
            StMemWr:  if (mem_ready) w_state_next = StFetch;
            StExec:   w_state_next = StAluWb;
            StAddiEx: w_state_next = StAddiWb;
            StMemWb, StAluWb, StAddiWb, StBranch, StJump: w_state_next = StFetch;
            default:  w_state_next = StFetch;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        illegal    = 1'b0;
        w_addr_sel = 1'b0;
        w_ir_we    = 1'b0;
        w_mdr_we   = 1'b0;
        w_ab_we    = 1'b0;
        w_alu_we   = 1'b0;
        w_alu_a    = r_a;
        w_alu_b    = w_imm_se;
        w_alu_ctl  = AluAdd;
        w_pc_br    = 1'b0;
        w_pc_jmp   = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rt;
        w_rf_wdata = r_aluout;
        unique case (r_state)
            StFetch: begin
                mem_req = 1'b1;
                w_ir_we = mem_ready;
            end
            StDecode: begin
                // Branch target is computed speculatively from the already-advanced PC.
                illegal  = ~w_legal;
                w_ab_we  = 1'b1;
                w_alu_we = 1'b1;
                w_alu_a  = r_pc;
                w_alu_b  = {w_imm_se[29:0], 2'b00};
            end
            StMemAdr, StAddiEx: w_alu_we = 1'b1;
            StMemRd: begin
                mem_req    = 1'b1;
                w_addr_sel = 1'b1;
                w_mdr_we   = mem_ready;
            end
            StMemWb: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = r_mdr;
            end
            StMemWr: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                w_addr_sel = 1'b1;
            end
            StExec: begin
                w_alu_we  = 1'b1;
                w_alu_b   = r_b;
                w_alu_ctl = w_funct_ctl;
            end
            StAluWb: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rd;
            end
            StAddiWb: w_rf_we  = 1'b1;
            StBranch: w_pc_br  = w_take;
            StJump:   w_pc_jmp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_mdr    <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
        end else begin
            if (w_ir_we) begin
                r_ir <= mem_rdata;
                r_pc <= r_pc + 32'd4;
            end else if (w_pc_br) begin
                r_pc <= r_aluout;
            end else if (w_pc_jmp) begin
                r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            end
            if (w_mdr_we) r_mdr <= mem_rdata;
            if (w_ab_we) begin
                r_a <= w_rs_val;
                r_b <= w_rt_val;
            end
            if (w_alu_we) r_aluout <= w_alu_y;
        end
    end

    // Not reset; writes only come from writeback states, which reset cannot be in.
    always_ff @(posedge clk) begin
        if (w_rf_we && (w_rf_waddr != 5'd0)) r_rf[w_rf_waddr] <= w_rf_wdata;
    end

    assign w_byte_addr = w_addr_sel ? r_aluout : r_pc;
    assign w_addr_full = w_byte_addr & ~32'h3;
    assign mem_addr    = w_addr_full[ADDR_WIDTH-1:0];
    assign mem_wdata   = r_b;
    assign pc          = r_pc;
    assign w_unused    = ^{r_ir[10:6], w_addr_full};
endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: runs a table of instructions with per-row latency,
// PC, illegal-pulse and register expectations, then checks reset mid-transaction.
module tb_mips_multicycle;
    localparam logic [31:0] ResetPc = 32'h40;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, mem_wdata, mem_rdata, mem_addr;
    logic        mem_req, mem_we, mem_ready, illegal;

    mips_multicycle #(.RESET_PC(ResetPc), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [512];
    int fetch_waits = 0;
    int data_waits  = 0;
    int w_cnt       = 0;
    logic is_fetch, hs;
    assign is_fetch  = mem_req && !mem_we && (mem_addr == pc);
    assign mem_ready = (w_cnt >= (is_fetch ? fetch_waits : data_waits));
    assign hs        = is_fetch && mem_ready;
    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (mem_req && !mem_ready) w_cnt <= w_cnt + 1;
        else                       w_cnt <= 0;
        if (mem_req && mem_ready && mem_we) mem[mem_addr[10:2]] <= mem_wdata;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          waits;
        int          lat;
        int          ill_n;
        int          rd;
        logic [31:0] rval;
        bit          st_chk;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] addr, instr, input int waits, lat, ill_n,
                                rd, input logic [31:0] rval, input bit st_chk);
        vec_t v;
        v.addr = addr; v.instr = instr; v.waits = waits; v.lat = lat; v.ill_n = ill_n;
        v.rd = rd; v.rval = rval; v.st_chk = st_chk;
        return v;
    endfunction

    initial begin
        int cyc, ill;
        bit done;
        vec_t v;
        vecs.push_back(mk(32'h40, enc_i(6'h08, 0, 2, 16'd5), 0, 4, 0, 2, 32'd5, 0));
        vecs.push_back(mk(32'h44, enc_r(2, 2, 3, 6'h20), 0, 4, 0, 3, 32'd10, 0));
        vecs.push_back(mk(32'h48, enc_i(6'h2b, 0, 3, 16'd8), 3, 7, 0, -1, 32'd0, 1));
        vecs.push_back(mk(32'h4c, enc_i(6'h23, 0, 4, 16'd8), 3, 8, 0, 4, 32'd10, 0));
        vecs.push_back(mk(32'h50, enc_r(2, 3, 5, 6'h22), 0, 4, 0, 5, 32'hffff_fffb, 0));
        vecs.push_back(mk(32'h54, enc_r(2, 3, 6, 6'h25), 0, 4, 0, 6, 32'd15, 0));
        vecs.push_back(mk(32'h58, enc_r(3, 5, 7, 6'h24), 0, 4, 0, 7, 32'd10, 0));
        vecs.push_back(mk(32'h5c, enc_r(5, 2, 8, 6'h2a), 0, 4, 0, 8, 32'd1, 0));
        vecs.push_back(mk(32'h60, enc_r(2, 5, 9, 6'h2a), 0, 4, 0, 9, 32'd0, 0));
        vecs.push_back(mk(32'h64, enc_i(6'h08, 0, 0, 16'd7), 0, 4, 0, 0, 32'd0, 0));
        vecs.push_back(mk(32'h68, enc_i(6'h04, 2, 0, 16'hffff), 0, 3, 0, -1, 32'd0, 0));
        vecs.push_back(mk(32'h6c, enc_i(6'h04, 2, 2, 16'd1), 0, 3, 0, -1, 32'd0, 0));
        vecs.push_back(mk(32'h74, enc_i(6'h04, 0, 0, 16'd2), 0, 3, 0, -1, 32'd0, 0));
        vecs.push_back(mk(32'h80, {6'h02, 26'h100}, 0, 3, 0, -1, 32'd0, 0));
        vecs.push_back(mk(32'h400, 32'hfc00_0000, 0, 2, 1, -1, 32'd0, 0));
`ifdef MIPS_MC_BNE_EN
        vecs.push_back(mk(32'h404, enc_i(6'h05, 2, 0, 16'd2), 0, 3, 0, -1, 32'd0, 0));
`else
        vecs.push_back(mk(32'h404, enc_i(6'h05, 2, 0, 16'd2), 0, 2, 1, -1, 32'd0, 0));
        vecs.push_back(mk(32'h408, enc_r(1, 2, 3, 6'h3f), 0, 2, 1, 3, 32'd10, 0));
        vecs.push_back(mk(32'h40c, enc_i(6'h08, 0, 10, 16'hffff), 0, 4, 0, 10, 32'hffff_ffff, 0));
`endif
        vecs.push_back(mk(32'h410, enc_i(6'h04, 2, 2, 16'hffff), 0, 3, 0, -1, 32'd0, 0));
        vecs.push_back(mk(32'h410, enc_i(6'h04, 2, 2, 16'hffff), 0, 3, 0, -1, 32'd0, 0));

        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        foreach (vecs[i]) mem[vecs[i].addr[10:2]] = vecs[i].instr;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, ResetPc);
        check("rst_req", {31'd0, mem_req}, 32'd1);
        check("rst_addr", mem_addr, ResetPc);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        check("first_fetch_hs", {31'd0, hs}, 32'd1);

        foreach (vecs[i]) begin
            v = vecs[i];
            check($sformatf("fetch_addr[%0d]", i), mem_addr, v.addr);
            data_waits = v.waits;
            cyc  = 0;
            ill  = 0;
            done = 1'b0;
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) check($sformatf("pc_plus4[%0d]", i), pc, v.addr + 32'd4);
                if (illegal) ill++;
                if (mem_req && mem_we) begin
                    check($sformatf("st_addr[%0d]", i), mem_addr, 32'd8);
                    check($sformatf("st_wdata[%0d]", i), mem_wdata, 32'd10);
                end
                done = hs;
            end
            check($sformatf("latency[%0d]", i), cyc, v.lat);
            check($sformatf("illegal_n[%0d]", i), ill, v.ill_n);
            if (v.rd >= 0) check($sformatf("rf[%0d] row %0d", v.rd, i), dut.r_rf[v.rd], v.rval);
        end
        check("mem_word8", mem[2], 32'd10);

        // Stall a fetch, then reset in the middle of it.
        fetch_waits = 5;
        @(negedge clk);
        check("stall_req", {31'd0, mem_req && !mem_ready}, 32'd1);
        check("stall_addr", mem_addr, 32'h410);
        @(negedge clk);
        check("stall_addr_hold", mem_addr, 32'h410);
        reset = 1'b1;
        #1;
        check("midrst_pc", pc, ResetPc);
        check("midrst_addr", mem_addr, ResetPc);
        check("midrst_req", {31'd0, mem_req}, 32'd1);
        check("midrst_illegal", {31'd0, illegal}, 32'd0);
        fetch_waits = 0;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_hs", {31'd0, hs}, 32'd1);
        @(negedge clk);
        check("post_rst_pc", pc, 32'h44);
        check("req_drop", {31'd0, mem_req}, 32'd0);
        check("rf4_kept", dut.r_rf[4], 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
